banco_registradores: RTL and testbench
======================================

BANCO_REGISTRADORES -- requirements
Module: banco_registradores

Interface
REQ-001 Parameter LARGURA, default 32: data width of every register and operand output.
REQ-002 Parameter NUM_REGS, default 32: register count; address width is log2(NUM_REGS) = 5.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 lerA_end  input  5  read address for operand A (rs).
REQ-006 lerB_end  input  5  read address for operand B (rt).
REQ-007 ler_valido  input  1  decode presents a valid read request this cycle.
REQ-008 stall  input  1  hold the operand stage; outputs and saida_valida keep their values.
REQ-009 flush  input  1  kill the operand stage contents.
REQ-010 escr_en  input  1  writeback enable.
REQ-011 escr_end  input  5  writeback address.
REQ-012 escr_dado  input  LARGURA  writeback data.
REQ-013 entradaA  output  LARGURA  registered operand A; feeds ALU entradaA.
REQ-014 entradaB  output  LARGURA  registered operand B; feeds ALU entradaB.
REQ-015 saida_valida  output  1  entradaA/entradaB hold a valid operand pair.

Function
REQ-016 The array SHALL hold NUM_REGS registers; register 0 SHALL always read 0, and writes to address 0 SHALL be ignored.
REQ-017 On a rising edge with escr_en=1 and escr_end!=0, reg[escr_end] SHALL become escr_dado; the write SHALL proceed regardless of stall and flush.
REQ-018 Read latency SHALL be one cycle: on a rising edge with stall=0 and flush=0, entradaA/entradaB SHALL capture the operands for lerA_end/lerB_end, and saida_valida SHALL capture ler_valido.
REQ-019 Operand selection per port SHALL be: address 0 -> 0; otherwise (escr_en=1 and escr_end equal to the read address) -> escr_dado (write-through bypass); otherwise -> reg[address].
REQ-020 With stall=1 and flush=0, entradaA, entradaB and saida_valida SHALL hold; the read addresses of the held pair SHALL also be held internally.
REQ-021 During stall with saida_valida=1, a write (escr_en=1, escr_end!=0) matching a held address SHALL update the corresponding held operand with escr_dado on that edge, so the held pair is never stale. Both ports SHALL update if both addresses match.
REQ-022 flush=1 SHALL take priority over stall: on the edge, saida_valida SHALL become 0 and entradaA/entradaB SHALL become 0.
REQ-023 Inputs ler_valido, lerA_end and lerB_end SHALL be ignored on any edge where stall=1 or flush=1.
REQ-024 Outputs SHALL be registered only; there SHALL be no combinational path from any input to any output.

Reset
REQ-025 reset_n=0 SHALL immediately, without waiting for a clock, clear all NUM_REGS registers, entradaA, entradaB, saida_valida and the held addresses to 0.
REQ-026 Reset asserted mid-stall or mid-write SHALL discard the pending operation; no write SHALL take effect on the edge where reset_n is low.
REQ-027 After reset_n deasserts, the first capturing edge SHALL behave exactly as REQ-018.

Structure
REQ-028 LARGURA, NUM_REGS and the address width constant SHALL reside in a shared package also used by the ALU.
REQ-029 Register storage and the REQ-019 bypass mux SHALL form one sub-module, registradores_nucleo. The operand latch, stall/flush control and held-address refresh SHALL remain in the top module.

Verification
REQ-030 Reset, then write reg5=0x0000_00AA; next cycle read A=5, B=0 with ler_valido=1 -> one cycle later entradaA=0x0000_00AA, entradaB=0, saida_valida=1.
REQ-031 Write reg0=0xFFFF_FFFF, then read A=0 -> entradaA=0; same-cycle write reg7=0x1234_5678 while reading B=7 -> entradaB=0x1234_5678 next cycle (bypass).
REQ-032 Capture A=3 (value 0x10); assert stall for 3 cycles while writing reg3=0x20 -> entradaA reads 0x10, then 0x20 after the write edge, held through the stall; saida_valida stays 1.
REQ-033 stall=1 and flush=1 on the same edge -> saida_valida=0, entradaA=entradaB=0; a concurrent write to reg9 still lands (verify with a later read of 9).
REQ-034 Drive reset_n low between clock edges with saida_valida=1 -> outputs are 0 before the next edge; a read of any address after release returns 0.
REQ-035 Back-to-back valid reads of all 31 nonzero registers after writing reg[i]=i -> each entradaA equals its address one cycle later, with no bubbles.

Source files
------------

// File: rtl/banco_registradores_pkg.sv
// banco_registradores_pkg
// Constants and types shared by the register file and the ALU.
//   LARGURA  : data width of every register and operand
//   NUM_REGS : number of architectural registers (register 0 is hardwired to 0)
//   END_W    : register address width
//   end_t    : register address type
package banco_registradores_pkg;

  localparam int LARGURA  = 32;
  localparam int NUM_REGS = 32;
  localparam int END_W    = $clog2(NUM_REGS);

  typedef logic [END_W-1:0] end_t;

endpackage

// File: rtl/banco_registradores_nucleo.sv
// registradores_nucleo
// Register storage with two combinational read ports and write-through bypass.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset (clears storage)
//   escr_en/end/dado      : writeback port; writes to address 0 are dropped
//   lerA_end, lerB_end    : read addresses
//   operA, operB          : selected operands (0 for address 0, bypassed write
//                           data when the writeback targets the same address)
module registradores_nucleo #(
  parameter int LARGURA  = banco_registradores_pkg::LARGURA,
  parameter int NUM_REGS = banco_registradores_pkg::NUM_REGS
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          escr_en,
  input  banco_registradores_pkg::end_t escr_end,
  input  logic [LARGURA-1:0]            escr_dado,
  input  banco_registradores_pkg::end_t lerA_end,
  input  banco_registradores_pkg::end_t lerB_end,
  output logic [LARGURA-1:0]            operA,
  output logic [LARGURA-1:0]            operB
);
  import banco_registradores_pkg::*;

  logic [LARGURA-1:0] regs [NUM_REGS];
  logic               escrita;

  // A write only counts when it targets a real (nonzero) register.
  assign escrita = escr_en && (escr_end != '0);

  // Storage: cleared asynchronously by reset, otherwise written on the rising
  // edge regardless of what the operand stage is doing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (escrita) begin
      regs[escr_end] <= escr_dado;
    end
  end

  // Read muxes: the bypass lets a read see the value being written on the same
  // edge, so a consumer never picks up the stale copy.
  always_comb begin
    operA = regs[lerA_end];
    operB = regs[lerB_end];
    if (lerA_end == '0) begin
      operA = '0;
    end else if (escrita && (escr_end == lerA_end)) begin
      operA = escr_dado;
    end
    if (lerB_end == '0) begin
      operB = '0;
    end else if (escrita && (escr_end == lerB_end)) begin
      operB = escr_dado;
    end
  end

endmodule

// File: rtl/banco_registradores.sv
// banco_registradores
// Register file with a registered operand stage feeding the ALU.
// Ports:
//   clk, reset_n               : clock, asynchronous active-low reset
//   lerA_end, lerB_end         : read addresses (rs, rt)
//   ler_valido                 : decode presents a valid read this cycle
//   stall                      : hold the operand stage
//   flush                      : kill the operand stage (wins over stall)
//   escr_en/escr_end/escr_dado : writeback port
//   entradaA, entradaB         : registered operands for the ALU
//   saida_valida               : entradaA/entradaB hold a valid pair
module banco_registradores #(
  parameter int LARGURA  = banco_registradores_pkg::LARGURA,
  parameter int NUM_REGS = banco_registradores_pkg::NUM_REGS
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  banco_registradores_pkg::end_t lerA_end,
  input  banco_registradores_pkg::end_t lerB_end,
  input  logic                          ler_valido,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          escr_en,
  input  banco_registradores_pkg::end_t escr_end,
  input  logic [LARGURA-1:0]            escr_dado,
  output logic [LARGURA-1:0]            entradaA,
  output logic [LARGURA-1:0]            entradaB,
  output logic                          saida_valida
);
  import banco_registradores_pkg::*;

  logic [LARGURA-1:0] operA;
  logic [LARGURA-1:0] operB;
  end_t               endA_q;
  end_t               endB_q;
  logic               refresca;

  registradores_nucleo #(
    .LARGURA  (LARGURA),
    .NUM_REGS (NUM_REGS)
  ) u_nucleo (
    .clk       (clk),
    .reset_n   (reset_n),
    .escr_en   (escr_en),
    .escr_end  (escr_end),
    .escr_dado (escr_dado),
    .lerA_end  (lerA_end),
    .lerB_end  (lerB_end),
    .operA     (operA),
    .operB     (operB)
  );

  // A held valid pair must track writebacks to its own registers; address 0
  // can never match because such writes are not real writes.
  assign refresca = saida_valida && escr_en && (escr_end != '0);

  // Operand stage: flush clears, stall holds (with refresh), otherwise the new
  // read is captured together with its addresses for later refresh.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entradaA     <= '0;
      entradaB     <= '0;
      saida_valida <= 1'b0;
      endA_q       <= '0;
      endB_q       <= '0;
    end else if (flush) begin
      entradaA     <= '0;
      entradaB     <= '0;
      saida_valida <= 1'b0;
      endA_q       <= '0;
      endB_q       <= '0;
    end else if (stall) begin
      if (refresca && (escr_end == endA_q)) begin
        entradaA <= escr_dado;
      end
      if (refresca && (escr_end == endB_q)) begin
        entradaB <= escr_dado;
      end
    end else begin
      entradaA     <= operA;
      entradaB     <= operB;
      saida_valida <= ler_valido;
      endA_q       <= lerA_end;
      endB_q       <= lerB_end;
    end
  end

endmodule

// File: tb/tb_banco_registradores.sv
// tb_banco_registradores
// Self-checking bench for banco_registradores: directed scenarios plus a
// randomized run, all compared against an array-based reference model.
module tb_banco_registradores;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  lerA_end, lerB_end, escr_end;
  logic        ler_valido, stall, flush, escr_en;
  logic [31:0] escr_dado;
  logic [31:0] entradaA, entradaB;
  logic        saida_valida;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mregs [32];
  logic [31:0] expA, expB;
  logic        expV;
  logic [4:0]  hA, hB;

  always #5 clk = ~clk;

  banco_registradores dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .lerA_end     (lerA_end),
    .lerB_end     (lerB_end),
    .ler_valido   (ler_valido),
    .stall        (stall),
    .flush        (flush),
    .escr_en      (escr_en),
    .escr_end     (escr_end),
    .escr_dado    (escr_dado),
    .entradaA     (entradaA),
    .entradaB     (entradaB),
    .saida_valida (saida_valida)
  );

  // Value a read of address a sees on an edge, given that edge's writeback
  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return mregs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    expA = 32'd0; expB = 32'd0; expV = 1'b0; hA = 5'd0; hB = 5'd0;
  endtask

  // Drive one clock cycle of inputs, advance the model, sample 1ns after the edge
  task automatic drive_cycle(input logic lv, input logic [4:0] ra, input logic [4:0] rb,
                             input logic st, input logic fl, input logic we,
                             input logic [4:0] wa, input logic [31:0] wd);
    ler_valido = lv; lerA_end = ra; lerB_end = rb;
    stall = st; flush = fl;
    escr_en = we; escr_end = wa; escr_dado = wd;
    if (fl) begin
      expA = 32'd0; expB = 32'd0; expV = 1'b0; hA = 5'd0; hB = 5'd0;
    end else if (st) begin
      if (expV && we && wa != 5'd0) begin
        if (wa == hA) expA = wd;
        if (wa == hB) expB = wd;
      end
    end else begin
      expA = model_read(ra, we, wa, wd);
      expB = model_read(rb, we, wa, wd);
      expV = lv; hA = ra; hB = rb;
    end
    if (we && wa != 5'd0) mregs[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (entradaA !== 32'd0) begin errors++; $display("[TB] FAIL reset_A got=%h exp=%h", entradaA, 32'd0); end
    checks++; if (entradaB !== 32'd0) begin errors++; $display("[TB] FAIL reset_B got=%h exp=%h", entradaB, 32'd0); end
    checks++; if (saida_valida !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", saida_valida); end
    reset_n = 1'b1;
  endtask

  task automatic test_leitura_basica();
    drive_cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_00AA);
    drive_cycle(1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (entradaA !== 32'h0000_00AA) begin errors++; $display("[TB] FAIL basic_A got=%h exp=%h", entradaA, 32'h0000_00AA); end
    checks++; if (entradaB !== 32'd0) begin errors++; $display("[TB] FAIL basic_B got=%h exp=%h", entradaB, 32'd0); end
    checks++; if (saida_valida !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid got=%b exp=1", saida_valida); end
  endtask

  task automatic test_bypass();
    drive_cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    drive_cycle(1'b1, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 32'h1234_5678);
    checks++; if (entradaA !== 32'd0) begin errors++; $display("[TB] FAIL reg0_read got=%h exp=%h", entradaA, 32'd0); end
    checks++; if (entradaB !== 32'h1234_5678) begin errors++; $display("[TB] FAIL bypass_B got=%h exp=%h", entradaB, 32'h1234_5678); end
    drive_cycle(1'b1, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (entradaA !== 32'h1234_5678) begin errors++; $display("[TB] FAIL reg7_stored got=%h exp=%h", entradaA, 32'h1234_5678); end
  endtask

  task automatic test_stall();
    drive_cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h10);
    drive_cycle(1'b1, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (entradaA !== 32'h10) begin errors++; $display("[TB] FAIL stall_capture got=%h exp=%h", entradaA, 32'h10); end
    // Read inputs during stall are noise that must be ignored
    drive_cycle(1'b0, 5'd12, 5'd13, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (entradaA !== 32'h10) begin errors++; $display("[TB] FAIL stall_hold1 got=%h exp=%h", entradaA, 32'h10); end
    checks++; if (saida_valida !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid1 got=%b exp=1", saida_valida); end
    drive_cycle(1'b0, 5'd14, 5'd15, 1'b1, 1'b0, 1'b1, 5'd3, 32'h20);
    checks++; if (entradaA !== 32'h20) begin errors++; $display("[TB] FAIL stall_refresh got=%h exp=%h", entradaA, 32'h20); end
    checks++; if (entradaB !== 32'd0) begin errors++; $display("[TB] FAIL stall_B_kept got=%h exp=%h", entradaB, 32'd0); end
    drive_cycle(1'b1, 5'd16, 5'd17, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (entradaA !== 32'h20) begin errors++; $display("[TB] FAIL stall_hold3 got=%h exp=%h", entradaA, 32'h20); end
    checks++; if (saida_valida !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid3 got=%b exp=1", saida_valida); end
    // Both ports holding the same register refresh together
    drive_cycle(1'b1, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    drive_cycle(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h30);
    checks++; if (entradaA !== 32'h30) begin errors++; $display("[TB] FAIL stall_both_A got=%h exp=%h", entradaA, 32'h30); end
    checks++; if (entradaB !== 32'h30) begin errors++; $display("[TB] FAIL stall_both_B got=%h exp=%h", entradaB, 32'h30); end
    drive_cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_flush();
    drive_cycle(1'b1, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    drive_cycle(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd9, 32'hCAFE_0009);
    checks++; if (entradaA !== 32'd0) begin errors++; $display("[TB] FAIL flush_A got=%h exp=%h", entradaA, 32'd0); end
    checks++; if (entradaB !== 32'd0) begin errors++; $display("[TB] FAIL flush_B got=%h exp=%h", entradaB, 32'd0); end
    checks++; if (saida_valida !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got=%b exp=0", saida_valida); end
    drive_cycle(1'b1, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (entradaA !== 32'hCAFE_0009) begin errors++; $display("[TB] FAIL flush_write_landed got=%h exp=%h", entradaA, 32'hCAFE_0009); end
  endtask

  task automatic test_async_reset();
    logic [4:0] addr;
    drive_cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h44);
    drive_cycle(1'b1, 5'd4, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (saida_valida !== 1'b1) begin errors++; $display("[TB] FAIL prereset_valid got=%b exp=1", saida_valida); end
    // Assert reset between edges with a write pending on the next edge
    #2;
    escr_en = 1'b1; escr_end = 5'd4; escr_dado = 32'hDEAD_BEEF; stall = 1'b1;
    reset_n = 1'b0;
    #1;
    checks++; if (entradaA !== 32'd0) begin errors++; $display("[TB] FAIL async_A got=%h exp=%h", entradaA, 32'd0); end
    checks++; if (entradaB !== 32'd0) begin errors++; $display("[TB] FAIL async_B got=%h exp=%h", entradaB, 32'd0); end
    checks++; if (saida_valida !== 1'b0) begin errors++; $display("[TB] FAIL async_valid got=%b exp=0", saida_valida); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    addr = 5'($urandom_range(1, 31));
    drive_cycle(1'b1, 5'd4, addr, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (entradaA !== 32'd0) begin errors++; $display("[TB] FAIL postreset_reg4 got=%h exp=%h", entradaA, 32'd0); end
    checks++; if (entradaB !== 32'd0) begin errors++; $display("[TB] FAIL postreset_any got=%h exp=%h addr=%0d", entradaB, 32'd0, addr); end
    checks++; if (saida_valida !== 1'b1) begin errors++; $display("[TB] FAIL postreset_valid got=%b exp=1", saida_valida); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] rb;
    for (int i = 1; i < 32; i++) begin
      drive_cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'(i), 32'(i));
    end
    for (int i = 1; i < 32; i++) begin
      rb = 5'($urandom_range(0, 31));
      drive_cycle(1'b1, 5'(i), rb, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      checks++; if (entradaA !== 32'(i)) begin errors++; $display("[TB] FAIL b2b_A[%0d] got=%h exp=%h", i, entradaA, 32'(i)); end
      checks++; if (entradaB !== expB) begin errors++; $display("[TB] FAIL b2b_B[%0d] got=%h exp=%h", i, entradaB, expB); end
      checks++; if (saida_valida !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid[%0d] got=%b exp=1", i, saida_valida); end
    end
  endtask

  task automatic test_random();
    logic       lv, st, fl, we;
    logic [4:0] ra, rb, wa;
    logic [31:0] wd;
    for (int n = 0; n < 400; n++) begin
      lv = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 9) == 0);
      we = 1'($urandom_range(0, 1));
      ra = 5'($urandom_range(0, 31));
      rb = 5'($urandom_range(0, 31));
      // Bias writes toward the held addresses so stall refresh gets exercised
      wa = ($urandom_range(0, 2) == 0) ? hA : 5'($urandom_range(0, 31));
      wd = $urandom;
      drive_cycle(lv, ra, rb, st, fl, we, wa, wd);
      checks++; if (entradaA !== expA) begin errors++; $display("[TB] FAIL rand_A[%0d] got=%h exp=%h", n, entradaA, expA); end
      checks++; if (entradaB !== expB) begin errors++; $display("[TB] FAIL rand_B[%0d] got=%h exp=%h", n, entradaB, expB); end
      checks++; if (saida_valida !== expV) begin errors++; $display("[TB] FAIL rand_valid[%0d] got=%b exp=%b", n, saida_valida, expV); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b0;
    ler_valido = 1'b0; lerA_end = 5'd0; lerB_end = 5'd0;
    stall = 1'b0; flush = 1'b0;
    escr_en = 1'b0; escr_end = 5'd0; escr_dado = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_leitura_basica();
    test_bypass();
    test_stall();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
